ex_muldiv: RTL
==============

Name: ex_muldiv

Overview:
- Execute-stage multi-cycle multiply/divide unit with architectural HI/LO registers.
- Consumes the decoded operation and operand values produced by the ID/EX pipeline register.
- Raises a stall request so ID/EX and earlier stages hold while an iterative MULT/DIV is in flight.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.

Parameters:
XLEN, 32, operand width; iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on the falling edge, matching the pipeline registers.
rst_n  input  1  asynchronous active-low reset.
op_valid  input  1  an operation is presented this cycle.
op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHILO (read only).
rs_data  input  XLEN  first operand (read_data1 of ID/EX).
rt_data  input  XLEN  second operand (read_data2 of ID/EX).
flush  input  1  abort the in-flight operation; discard any presented op.
stall  output  1  combinational: busy & op_valid & (op != 0).
busy  output  1  iterative operation in progress.
done  output  1  one-cycle pulse after HI/LO are written by MULT/DIV.
hi  output  XLEN  HI register.
lo  output  XLEN  LO register.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0. Takes effect mid-operation immediately; the partial result is lost.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - op_valid & !flush & op in {1,2}: latch operands, go MUL, busy=1.
  - op in {3,4}: go DIV.
  - op 5: hi<=rs_data. op 6: lo<=rs_data. Single edge, no busy.
  - op 0/7: no state change. MFHI/MFLO selection is done outside the block from hi/lo.
- Signed ops (1,3): take magnitudes first; record result sign (MULT: sign_a^sign_b; DIV: quotient sign_a^sign_b, remainder sign_a).
- MUL: shift-add, one multiplier bit per edge over a 2*XLEN product, XLEN edges, then FIX.
- DIV: restoring division, one quotient bit per edge, XLEN edges, then FIX.
- FIX (one edge): apply two's-complement sign correction and write HI/LO; busy falls and done=1 for the following cycle.
  - MUL: hi = product[2*XLEN-1:XLEN], lo = product[XLEN-1:0].
  - DIV: lo = quotient, hi = remainder.
- Latency: accept edge E0; iterations E1..E32; HI/LO written at E33. busy is high from after E0 until E33; done is high E33..E34.
- Divide by zero (rt_data==0): still takes the full latency; hi=rs_data, lo=all ones. Applies to both DIV and DIVU; no exception.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap).
- While busy:
  - Any op_valid with op!=0 asserts stall; the op is not consumed.
  - A new MULT/DIV/MT/MF is accepted only on the edge after busy falls, i.e. in the done cycle.
  - hi/lo hold their old values until E33.
- flush while busy: at the next edge go IDLE, busy=0, no done, hi/lo unchanged.
- flush in IDLE suppresses acceptance that cycle.
- flush in FIX: the write is still suppressed and hi/lo are unchanged.
- done and a new accept may coincide: done pulses while the new op starts.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy for 33 edges, then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0x64 rt=0 -> hi=0x64, lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 in consecutive cycles -> hi=0x1234, lo=0x5678, busy never set. MFHILO presented while a MULT is busy -> stall=1 until busy falls; hi/lo old values until E33.
- MULT 5*6 started, flush asserted at edge E10 -> busy=0 at E11, done never pulses, hi/lo keep prior values (0x1234/0x5678).
- DIVU 9/2 started, rst_n pulled low at E15 -> immediately busy=0, hi=lo=0. After release, MULTU 3*4 -> lo=12, hi=0.

Source files
------------

// File: rtl/ex_muldiv.sv
// Execute-stage iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per falling edge, then a sign-fix cycle.
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned CW = $clog2(XLEN);

    localparam logic [2:0] OpNop   = 3'd0;
    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     mplier_q;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     quo_q;
    logic [XLEN-1:0]     divisor_q;
    logic [XLEN-1:0]     a_raw_q;
    logic                neg_q;
    logic                neg_rem_q;
    logic                dz_q;
    logic                is_div_q;
    logic                done_q;
    logic [XLEN-1:0]     hi_q;
    logic [XLEN-1:0]     lo_q;

    logic                signed_op;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;
    logic                last_iter;

    always_comb begin
        signed_op = (op == OpMult) || (op == OpDiv);
        mag_a     = (signed_op && rs_data[XLEN-1]) ? -rs_data : rs_data;
        mag_b     = (signed_op && rt_data[XLEN-1]) ? -rt_data : rt_data;
        // Partial remainder stays below the divisor, so XLEN bits suffice between steps.
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, divisor_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
        quo_fix   = neg_q ? -quo_q : quo_q;
        rem_fix   = neg_rem_q ? -rem_q : rem_q;
        last_iter = (cnt_q == CW'(XLEN - 1));
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            a_raw_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (op_valid && !flush) begin
                        case (op)
                            OpMult, OpMultu: begin
                                mcand_q  <= {{XLEN{1'b0}}, mag_a};
                                mplier_q <= mag_b;
                                acc_q    <= '0;
                                neg_q    <= signed_op & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                                is_div_q <= 1'b0;
                                cnt_q    <= '0;
                                state_q  <= StMul;
                            end
                            OpDiv, OpDivu: begin
                                rem_q     <= '0;
                                quo_q     <= mag_a;
                                divisor_q <= mag_b;
                                neg_q     <= signed_op & (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
                                neg_rem_q <= signed_op & rs_data[XLEN-1];
                                dz_q      <= (rt_data == '0);
                                a_raw_q   <= rs_data;
                                is_div_q  <= 1'b1;
                                cnt_q     <= '0;
                                state_q   <= StDiv;
                            end
                            OpMthi:  hi_q <= rs_data;
                            OpMtlo:  lo_q <= rs_data;
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                        if (last_iter) begin
                            state_q <= StFix;
                        end
                    end
                end
                StDiv: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else begin
                        if (!div_diff[XLEN]) begin
                            rem_q <= div_diff[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q <= div_shift[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q + CW'(1);
                        if (last_iter) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    if (!flush) begin
                        done_q <= 1'b1;
                        if (!is_div_q) begin
                            hi_q <= prod_fix[2*XLEN-1:XLEN];
                            lo_q <= prod_fix[XLEN-1:0];
                        end else if (dz_q) begin
                            // Divide by zero: dividend to HI, all ones to LO, no trap.
                            hi_q <= a_raw_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy  = (state_q != StIdle);
    assign stall = busy & op_valid & (op != OpNop);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
